// File: rtl/riscv_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Holds the forwarding select codes, the shadow-stage record and the match functions.
package riscv_hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_info_t;

    // True when an in-flight stage writes a register that the D instruction reads; x0 never counts.
    function automatic logic stageHits(
        input stage_info_t           s,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  useRs1,
        input logic                  useRs2
    );
        return s.regwrite && (s.rd != '0) &&
               ((useRs1 && (s.rd == rs1)) || (useRs2 && (s.rd == rs2)));
    endfunction

    // M is checked before W so the newest producer wins.
    function automatic fwd_sel_t fwdSelect(
        input stage_info_t           m,
        input stage_info_t           w,
        input logic [REG_ADDR_W-1:0] rs
    );
        if (m.regwrite && (m.rd != '0) && (m.rd == rs)) begin
            return FWD_MEM;
        end
        if (w.regwrite && (w.rd != '0) && (w.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: async reset, synchronous flush to an all-zero bubble.
module hazard_stage_reg
    import riscv_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  stage_info_t i_d,
    output stage_info_t o_q
);

    stage_info_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for a 5-stage RV32I pipeline.
// Shadows rd/rs of the E, M, W instructions and drives the EX forwarding selects and F/D/E stall/flush.
module hazard_forward_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  use_rs1_d,
    input  logic                  use_rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  regwrite_d,
    input  logic                  memread_d,
    input  logic                  pcsrc_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_cnt
);

    stage_info_t w_dInfo;
    stage_info_t w_mIn;
    stage_info_t w_stageE;
    stage_info_t w_stageM;
    stage_info_t w_stageW;

    logic w_hitE;
    logic w_hitM;
    logic w_hitW;
    logic w_stall;
    logic w_unusedBits;

    logic [CNT_W-1:0] r_stallCnt;

    // Source-register fields only matter in E, so later stages carry zeros there.
    always_comb begin
        w_dInfo          = '0;
        w_dInfo.rs1      = rs1_d;
        w_dInfo.rs2      = rs2_d;
        w_dInfo.rd       = rd_d;
        w_dInfo.regwrite = regwrite_d;
        w_dInfo.memread  = memread_d;
        w_mIn            = w_stageE;
        w_mIn.rs1        = '0;
        w_mIn.rs2        = '0;
    end

    hazard_stage_reg u_stageE (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_e),
        .i_d     (w_dInfo),
        .o_q     (w_stageE)
    );

    hazard_stage_reg u_stageM (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_d     (w_mIn),
        .o_q     (w_stageM)
    );

    hazard_stage_reg u_stageW (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_d     (w_stageM),
        .o_q     (w_stageW)
    );

    assign w_hitE = stageHits(w_stageE, rs1_d, rs2_d, use_rs1_d, use_rs2_d);
    assign w_hitM = stageHits(w_stageM, rs1_d, rs2_d, use_rs1_d, use_rs2_d);
    assign w_hitW = stageHits(w_stageW, rs1_d, rs2_d, use_rs1_d, use_rs2_d);

    // Without forwarding every RAW dependency must drain through the register file.
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        w_stall     = 1'b0;
        if (FWD_EN != 0) begin
            forward_a_e = fwdSelect(w_stageM, w_stageW, w_stageE.rs1);
            forward_b_e = fwdSelect(w_stageM, w_stageW, w_stageE.rs2);
            w_stall     = w_stageE.memread && w_hitE;
        end else begin
            w_stall     = w_hitE || w_hitM || w_hitW;
        end
    end

    assign stall_f = w_stall && !pcsrc_e;
    assign stall_d = w_stall && !pcsrc_e;
    assign flush_d = pcsrc_e;
    assign flush_e = w_stall || pcsrc_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (stall_d && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stallCnt;

    assign w_unusedBits = ^{w_stageM.rs1, w_stageM.rs2, w_stageM.memread,
                            w_stageW.rs1, w_stageW.rs2, w_stageW.memread};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized self-checking bench: a forwarding and a non-forwarding instance share stimulus
// and are compared against an instruction-history model of the hazard rules.
module tb_hazard_forward_ctrl;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [4:0] rs1D, rs2D, rdD;
    logic       useRs1D, useRs2D, regwriteD, memreadD, pcsrcE;

    logic [1:0]  fa0, fb0, fa1, fb1;
    logic        sf0, sd0, fd0, fe0, sf1, sd1, fd1, fe1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int checkCount = 0;
    int failCount  = 0;

    rec_t histNo[$];
    rec_t histFwd[$];
    rec_t prevD;
    bit   prevFlushE[2];
    bit   prevStall[2];
    int   expCnt[2];
    int   cntMax[2] = '{15, 65535};

    hazard_forward_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(4)) dutNoFwd (
        .clk(clk), .rst(rst), .rs1_d(rs1D), .rs2_d(rs2D), .use_rs1_d(useRs1D),
        .use_rs2_d(useRs2D), .rd_d(rdD), .regwrite_d(regwriteD), .memread_d(memreadD),
        .pcsrc_e(pcsrcE), .forward_a_e(fa0), .forward_b_e(fb0), .stall_f(sf0),
        .stall_d(sd0), .flush_d(fd0), .flush_e(fe0), .stall_cnt(cnt0)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(16)) dutFwd (
        .clk(clk), .rst(rst), .rs1_d(rs1D), .rs2_d(rs2D), .use_rs1_d(useRs1D),
        .use_rs2_d(useRs2D), .rd_d(rdD), .regwrite_d(regwriteD), .memread_d(memreadD),
        .pcsrc_e(pcsrcE), .forward_a_e(fa1), .forward_b_e(fb1), .stall_f(sf1),
        .stall_d(sd1), .flush_d(fd1), .flush_e(fe1), .stall_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic rec_t getHist(input int c, input int idx);
        return (c == 1) ? histFwd[idx] : histNo[idx];
    endfunction

    function automatic bit writesDSource(input rec_t x);
        if (!x.rw || x.rd == 5'd0) return 1'b0;
        return (useRs1D && x.rd == rs1D) || (useRs2D && x.rd == rs2D);
    endfunction

    function automatic logic [1:0] expFwd(input rec_t m, input rec_t w, input logic [4:0] rs);
        if (m.rw && m.rd != 5'd0 && m.rd == rs) return 2'b10;
        if (w.rw && w.rd != 5'd0 && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic rec_t zeroRec();
        rec_t z;
        z.rs1 = 5'd0; z.rs2 = 5'd0; z.rd = 5'd0; z.rw = 1'b0; z.mr = 1'b0;
        return z;
    endfunction

    task automatic modelReset();
        histNo.delete();
        histFwd.delete();
        for (int k = 0; k < 3; k++) begin
            histNo.push_back(zeroRec());
            histFwd.push_back(zeroRec());
        end
        expCnt[0] = 0;
        expCnt[1] = 0;
    endtask

    // Each clock edge the instruction that sat in D enters E (or a bubble), the oldest one retires.
    task automatic modelAdvance();
        rec_t older;
        for (int c = 0; c < 2; c++) begin
            rec_t entry;
            entry = prevFlushE[c] ? zeroRec() : prevD;
            if (c == 1) begin
                histFwd.push_front(entry);
                older = histFwd.pop_back();
            end else begin
                histNo.push_front(entry);
                older = histNo.pop_back();
            end
            if (prevStall[c] && expCnt[c] < cntMax[c]) expCnt[c]++;
        end
    endtask

    task automatic verifyCycle();
        for (int c = 0; c < 2; c++) begin
            rec_t e, m, w;
            bit rawStall, expStall, expFlushE;
            logic [1:0] oa, ob;
            logic os_f, os_d, of_d, of_e;
            logic [31:0] oc;
            e = getHist(c, 0);
            m = getHist(c, 1);
            w = getHist(c, 2);
            if (c == 1) rawStall = e.mr && writesDSource(e);
            else        rawStall = writesDSource(e) || writesDSource(m) || writesDSource(w);
            expStall  = rawStall && !pcsrcE;
            expFlushE = rawStall || pcsrcE;
            oa = (c == 1) ? fa1 : fa0;
            ob = (c == 1) ? fb1 : fb0;
            os_f = (c == 1) ? sf1 : sf0;
            os_d = (c == 1) ? sd1 : sd0;
            of_d = (c == 1) ? fd1 : fd0;
            of_e = (c == 1) ? fe1 : fe0;
            oc = (c == 1) ? {16'd0, cnt1} : {28'd0, cnt0};
            checkOutput($sformatf("c%0d_fwdA", c), {30'd0, oa}, {30'd0, (c == 1) ? expFwd(m, w, e.rs1) : 2'b00});
            checkOutput($sformatf("c%0d_fwdB", c), {30'd0, ob}, {30'd0, (c == 1) ? expFwd(m, w, e.rs2) : 2'b00});
            checkOutput($sformatf("c%0d_stallF", c), {31'd0, os_f}, {31'd0, expStall});
            checkOutput($sformatf("c%0d_stallD", c), {31'd0, os_d}, {31'd0, expStall});
            checkOutput($sformatf("c%0d_flushD", c), {31'd0, of_d}, {31'd0, pcsrcE});
            checkOutput($sformatf("c%0d_flushE", c), {31'd0, of_e}, {31'd0, expFlushE});
            checkOutput($sformatf("c%0d_cnt", c), oc, expCnt[c]);
            prevFlushE[c] = expFlushE;
            prevStall[c]  = expStall;
        end
        prevD.rs1 = rs1D; prevD.rs2 = rs2D; prevD.rd = rdD;
        prevD.rw  = regwriteD; prevD.mr = memreadD;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic u1, input logic u2, input logic rw, input logic mr,
                                 input logic pc);
        @(posedge clk);
        #1;
        modelAdvance();
        rs1D = rs1; rs2D = rs2; rdD = rd;
        useRs1D = u1; useRs2D = u2; regwriteD = rw; memreadD = mr; pcsrcE = pc;
        #1;
        verifyCycle();
    endtask

    task automatic resetMidCycle();
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        verifyCycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        verifyCycle();
    endtask

    task automatic applyNop();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rs1D = '0; rs2D = '0; rdD = '0;
        useRs1D = 1'b0; useRs2D = 1'b0; regwriteD = 1'b0; memreadD = 1'b0; pcsrcE = 1'b0;
        prevFlushE = '{1'b0, 1'b0};
        prevStall  = '{1'b0, 1'b0};
        modelReset();
        #2;
        verifyCycle();
        #1;
        rst = 1'b0;
        #1;
        verifyCycle();

        // lw x5 then add x6,x5,x1: one bubble, then WB forward
        applyStimulus(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("loadUseStall", {31'd0, sd1}, 32'd1);
        applyStimulus(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyNop();
        checkOutput("loadUseFwdA", {30'd0, fa1}, 32'd1);
        checkOutput("loadUseCnt", {16'd0, cnt1}, 32'd1);

        // add x5 then sub x6,x5,x3
        applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyNop();
        // add x5, nop, or x7,x4,x5
        applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyNop();
        applyStimulus(5'd4, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyNop();
        // write x0 then read x0
        applyStimulus(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyNop();
        // taken branch coinciding with a load-use hazard
        applyStimulus(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'd9, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyNop();
        applyNop();
        // RAW in the non-forwarding core, reset while stalled
        applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rawStallNoFwd", {31'd0, sd0}, 32'd1);
        resetMidCycle();
        checkOutput("rawStallAfterRst", {31'd0, sd0}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic rw;
            rw = ($urandom % 4) != 0;
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'(($urandom % 4) != 0),
                          1'($urandom % 2), rw, 1'(rw && (($urandom % 3) == 0)),
                          1'(($urandom % 8) == 0));
            if (i == 200) resetMidCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
